// File: rtl/pipemem_pkg.sv
// pipemem_pkg: shared constants for the MEM-stage responder.
//   - MMIO word offsets (addr[4:2]) for the I/O window at addr[31] = 1
//   - bit positions inside IRQ_EN / IRQ_STAT
//   - bit positions inside TXSTAT
package pipemem_pkg;

  // MMIO word offsets, decoded from addr[4:2]
  localparam logic [2:0] OFS_CYCLE   = 3'd0;  // 0x00 RO  free-running cycle counter
  localparam logic [2:0] OFS_TXDATA  = 3'd1;  // 0x04 WO  push byte into TX FIFO
  localparam logic [2:0] OFS_TXSTAT  = 3'd2;  // 0x08 RO  FIFO status
  localparam logic [2:0] OFS_CMP     = 3'd3;  // 0x0C RW  timer compare value
  localparam logic [2:0] OFS_IRQEN   = 3'd4;  // 0x10 RW  interrupt enables
  localparam logic [2:0] OFS_IRQSTAT = 3'd5;  // 0x14 RW1C sticky interrupt flags

  // IRQ_EN / IRQ_STAT bit indices
  localparam int IRQ_TIMER = 0;
  localparam int IRQ_TX    = 1;

  // TXSTAT bit positions; count occupies [TXS_COUNT +: FIFO_AW+1]
  localparam int TXS_EMPTY = 0;
  localparam int TXS_FULL  = 1;
  localparam int TXS_OVF   = 2;
  localparam int TXS_COUNT = 3;

  // IRQ_STAT write also clears OVF when this wdata bit is set
  localparam int OVF_CLR_BIT = 2;

endpackage

// File: rtl/pipemem_txfifo.sv
// pipemem_txfifo: byte-wide synchronous FIFO feeding the TX consumer.
// Ports:
//   clock, resetn   rising-edge clock, synchronous active-low reset
//   push, din       enqueue request and byte
//   pop             dequeue request (ignored while empty)
//   dout            head byte; forced to 0 while empty
//   empty, full     status flags
//   count           occupancy, 0 .. 2^FIFO_AW
//   ovf_set         one-cycle pulse: a push was dropped because the FIFO was full
// A push while full is still accepted when a pop happens in the same cycle;
// the freed head slot is the one being written, and its old value has already
// been presented on dout before the edge.
module pipemem_txfifo #(
  parameter int FIFO_AW = 3
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             push,
  input  logic [7:0]       din,
  input  logic             pop,
  output logic [7:0]       dout,
  output logic             empty,
  output logic             full,
  output logic [FIFO_AW:0] count,
  output logic             ovf_set
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   cnt;
  logic               pop_ok;
  logic               push_ok;

  assign empty   = (cnt == '0);
  assign full    = (cnt == FULL_CNT);
  assign count   = cnt;
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign ovf_set = push & full & ~pop_ok;
  assign dout    = empty ? 8'h00 : mem[rd_ptr];

  // Storage is not reset; the empty gate on dout hides stale contents.
  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/pipemem_io.sv
// pipemem_io: MEM-stage responder for the pipelined CPU.
// Ports:
//   clock, resetn  rising-edge clock, synchronous active-low reset
//   we             store strobe (mwmem)
//   addr           byte address (malu); addr[31] selects MMIO, bits [1:0] ignored
//   wdata          store data (mb)
//   rdata          load data (mmo), combinational from addr
//   tx_data        head byte of the TX FIFO
//   tx_valid       TX FIFO not empty
//   tx_ready       consumer accepts tx_data this cycle
//   irq            OR of enabled sticky interrupt flags
// TX handshake: a byte transfers on every rising edge where tx_valid and
// tx_ready are both 1; while tx_valid is 1 and tx_ready is 0, tx_data holds
// its value, and tx_valid never drops without a transfer (except on reset).
// RAM: word-addressed, asynchronous read, write on the edge; a read of the
// address being written returns the old word during that cycle.
module pipemem_io
  import pipemem_pkg::*;
#(
  parameter int RAM_AW  = 5,
  parameter int FIFO_AW = 3
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        irq
);

  localparam int RAM_WORDS = 1 << RAM_AW;
  localparam logic [FIFO_AW:0] CNT_ONE = (FIFO_AW + 1)'(1);

  // ---------------- decode ----------------
  logic              sel_mmio;
  logic [2:0]        ofs;
  logic [RAM_AW-1:0] ram_idx;
  logic              mmio_we;

  assign sel_mmio = addr[31];
  assign ofs      = addr[4:2];
  assign ram_idx  = addr[RAM_AW+1:2];
  assign mmio_we  = we & sel_mmio;

  // Upper RAM address bits alias; byte-offset bits are ignored.
  logic unused_addr;
  assign unused_addr = ^{addr[30:RAM_AW+2], addr[1:0]};

  // ---------------- RAM ----------------
  logic [31:0] ram [RAM_WORDS];

  always_ff @(posedge clock) begin
    if (we && !sel_mmio) ram[ram_idx] <= wdata;
  end

  // ---------------- registers ----------------
  logic [31:0] cycle_q;
  logic [31:0] cmp_q;
  logic [1:0]  irq_en_q;
  logic [1:0]  irq_stat_q;
  logic        ovf_q;

  // ---------------- TX FIFO ----------------
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_empty;
  logic             fifo_full;
  logic [FIFO_AW:0] fifo_count;
  logic             fifo_ovf_set;

  assign fifo_push = mmio_we & (ofs == OFS_TXDATA);
  assign fifo_pop  = tx_valid & tx_ready;

  pipemem_txfifo #(.FIFO_AW(FIFO_AW)) u_txfifo (
    .clock   (clock),
    .resetn  (resetn),
    .push    (fifo_push),
    .din     (wdata[7:0]),
    .pop     (fifo_pop),
    .dout    (tx_data),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count),
    .ovf_set (fifo_ovf_set)
  );

  assign tx_valid = ~fifo_empty;

  // ---------------- event detection ----------------
  logic timer_hit;
  logic tx_drained;
  logic stat_wr;

  // Compare against the pre-increment counter value.
  assign timer_hit  = (cycle_q == cmp_q);
  // Last queued byte leaves: count goes 1 -> 0 (a same-cycle push keeps it at 1).
  assign tx_drained = fifo_pop & ~fifo_push & (fifo_count == CNT_ONE);
  assign stat_wr    = mmio_we & (ofs == OFS_IRQSTAT);

  // Sticky flags: a set event in the same cycle as a W1C clear wins.
  logic [1:0] irq_stat_d;
  logic       ovf_d;

  always_comb begin
    irq_stat_d = irq_stat_q;
    ovf_d      = ovf_q;
    if (stat_wr) begin
      irq_stat_d = irq_stat_q & ~wdata[1:0];
      if (wdata[OVF_CLR_BIT]) ovf_d = 1'b0;
    end
    if (timer_hit)    irq_stat_d[IRQ_TIMER] = 1'b1;
    if (tx_drained)   irq_stat_d[IRQ_TX]    = 1'b1;
    if (fifo_ovf_set) ovf_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      cycle_q    <= '0;
      cmp_q      <= '0;
      irq_en_q   <= '0;
      irq_stat_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      cycle_q    <= cycle_q + 32'd1;
      irq_stat_q <= irq_stat_d;
      ovf_q      <= ovf_d;
      if (mmio_we && ofs == OFS_CMP)   cmp_q    <= wdata;
      if (mmio_we && ofs == OFS_IRQEN) irq_en_q <= wdata[1:0];
    end
  end

  assign irq = |(irq_stat_q & irq_en_q);

  // ---------------- read mux ----------------
  logic [31:0] txstat;

  always_comb begin
    txstat                           = '0;
    txstat[TXS_EMPTY]                = fifo_empty;
    txstat[TXS_FULL]                 = fifo_full;
    txstat[TXS_OVF]                  = ovf_q;
    txstat[TXS_COUNT +: FIFO_AW + 1] = fifo_count;
  end

  always_comb begin
    rdata = '0;
    if (!sel_mmio) begin
      rdata = ram[ram_idx];
    end else begin
      case (ofs)
        OFS_CYCLE:   rdata = cycle_q;
        OFS_TXSTAT:  rdata = txstat;
        OFS_CMP:     rdata = cmp_q;
        OFS_IRQEN:   rdata = {30'd0, irq_en_q};
        OFS_IRQSTAT: rdata = {30'd0, irq_stat_q};
        default:     rdata = '0;
      endcase
    end
  end

endmodule
